// File: rtl/brightness_pkg.sv
// Shared types for the brightness scheduler.
// Fade build is selected with BRIGHTNESS_FADE_EN.
package brightness_pkg;

  localparam int BRIGHTNESS_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    APPLY,
    HOLD
  } ctrl_fsm_e;

  typedef enum logic {
    STEP_UP,
    STEP_DOWN
  } step_dir_e;

endpackage

// File: rtl/brightness_step_timer.sv
// Counts frame_start pulses while the scheduler holds between ramp steps.
// Only instantiated when BRIGHTNESS_FADE_EN is defined.
module brightness_step_timer
  import brightness_pkg::*;
#(
  parameter int FRAMES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic frame_start,
  output logic done
);

  localparam int CW = (FRAMES > 2) ? $clog2(FRAMES) : 1;
  localparam int LAST_I = (FRAMES > 1) ? FRAMES - 2 : 0;
  localparam logic [CW-1:0] LAST = CW'(LAST_I);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    done  = en && frame_start && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (frame_start) begin
      cnt_d = done ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/brightness_scheduler.sv
// Live brightness owner: arbitrates command/auto-dim and applies on frames.
// Define BRIGHTNESS_FADE_EN to ramp one code per step instead of jumping.
module brightness_scheduler
  import brightness_pkg::*;
#(
  parameter int BRIGHTNESS_LEVELS = BRIGHTNESS_W,
  parameter logic [BRIGHTNESS_LEVELS-1:0] BRIGHTNESS_RESET = '1,
  parameter int FADE_FRAMES_PER_STEP = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         frame_start,
  input  logic                         cmd_en,
  input  logic [BRIGHTNESS_LEVELS-1:0] cmd_data,
  input  logic                         auto_en,
  input  logic [BRIGHTNESS_LEVELS-1:0] auto_data,
  output logic                         auto_ack,
  output logic                         cmd_ack,
  output logic [BRIGHTNESS_LEVELS-1:0] brightness_out,
  output logic                         brightness_upd,
  output logic                         busy
);

  localparam int BL = BRIGHTNESS_LEVELS;

  ctrl_fsm_e state_q, state_d;
  logic [BL-1:0] target_q, target_d;
  logic [BL-1:0] bright_q, bright_d;
  logic [BL-1:0] next_val;
  logic cmd_ack_q, cmd_ack_d;
  logic auto_ack_q, auto_ack_d;
  logic upd_q, upd_d;
  logic auto_take;
  logic hold_done;

  // Auto is still high in its ack cycle; don't accept it twice.
  always_comb begin
    auto_take  = auto_en && !cmd_en && !auto_ack_q;
    cmd_ack_d  = cmd_en;
    auto_ack_d = auto_take;
    target_d   = target_q;
    if (cmd_en) begin
      target_d = cmd_data;
    end else if (auto_take) begin
      target_d = auto_data;
    end
  end

`ifdef BRIGHTNESS_FADE_EN
  step_dir_e dir;

  always_comb begin
    dir = (target_q > bright_q) ? STEP_UP : STEP_DOWN;
    if (target_q == bright_q) begin
      next_val = bright_q;
    end else if (dir == STEP_UP) begin
      next_val = bright_q + 1'b1;
    end else begin
      next_val = bright_q - 1'b1;
    end
  end

  brightness_step_timer #(
    .FRAMES(FADE_FRAMES_PER_STEP)
  ) u_step_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (state_q == HOLD),
    .frame_start(frame_start),
    .done       (hold_done)
  );
`else
  assign next_val  = target_q;
  assign hold_done = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    bright_d = bright_q;
    upd_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (target_q != bright_q) state_d = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (frame_start) begin
          bright_d = next_val;
          upd_d    = (next_val != bright_q);
          state_d  = upd_d ? APPLY : IDLE;
        end
      end
      APPLY: begin
`ifdef BRIGHTNESS_FADE_EN
        state_d = (FADE_FRAMES_PER_STEP > 1) ? HOLD : IDLE;
`else
        state_d = IDLE;
`endif
      end
      HOLD: begin
        if (hold_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      target_q   <= BRIGHTNESS_RESET;
      bright_q   <= BRIGHTNESS_RESET;
      cmd_ack_q  <= 1'b0;
      auto_ack_q <= 1'b0;
      upd_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      bright_q   <= bright_d;
      cmd_ack_q  <= cmd_ack_d;
      auto_ack_q <= auto_ack_d;
      upd_q      <= upd_d;
    end
  end

  assign cmd_ack        = cmd_ack_q;
  assign auto_ack       = auto_ack_q;
  assign brightness_out = bright_q;
  assign brightness_upd = upd_q;
  assign busy = (state_q != IDLE) || (target_q != bright_q);

endmodule

// File: tb/tb_brightness_scheduler.sv
// Directed bench for brightness_scheduler (BL=4, reset F, 2 frames/step).
// Fade scenarios run when BRIGHTNESS_FADE_EN is defined.
module tb_brightness_scheduler;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       cmd_en = 1'b0;
  logic [3:0] cmd_data = 4'h0;
  logic       auto_en = 1'b0;
  logic [3:0] auto_data = 4'h0;
  logic       auto_ack;
  logic       cmd_ack;
  logic [3:0] brightness_out;
  logic       brightness_upd;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;

  brightness_scheduler #(
    .BRIGHTNESS_LEVELS(4),
    .BRIGHTNESS_RESET(4'hF),
    .FADE_FRAMES_PER_STEP(2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .frame_start   (frame_start),
    .cmd_en        (cmd_en),
    .cmd_data      (cmd_data),
    .auto_en       (auto_en),
    .auto_data     (auto_data),
    .auto_ack      (auto_ack),
    .cmd_ack       (cmd_ack),
    .brightness_out(brightness_out),
    .brightness_upd(brightness_upd),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (brightness_upd) upd_cnt++;
  endtask

  task automatic req_cmd(input logic [3:0] v);
    cmd_en   = 1'b1;
    cmd_data = v;
    tick();
    check("cmd_ack", cmd_ack, 1);
    cmd_en = 1'b0;
  endtask

  task automatic fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

`ifdef BRIGHTNESS_FADE_EN
  int exp_f[6] = '{4, 4, 5, 5, 6, 6};

  task automatic ramp_to(input logic [3:0] v);
    int n;
    n = 0;
    while (brightness_out != v && n < 40) begin
      fs();
      tick();
      tick();
      n++;
    end
    check("ramp_end", brightness_out, v);
    fs();
    tick();
    tick();
    check("ramp_idle", busy, 0);
  endtask
`endif

  initial begin
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_out", brightness_out, 4'hF);
      check("rst_flags",
            {brightness_upd, cmd_ack, auto_ack, busy}, 0);
    end
    upd_cnt = 0;

`ifndef BRIGHTNESS_FADE_EN
    // direct jump one cycle after frame_start
    req_cmd(4'd3);
    check("ack_auto0", auto_ack, 0);
    check("busy_pend", busy, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_old", brightness_out, 4'hF);
    end
    check("cmd_ack_1cyc", cmd_ack, 0);
    fs();
    check("jump_out", brightness_out, 4'd3);
    check("jump_upd", brightness_upd, 1);
    tick();
    check("upd_once", brightness_upd, 0);
    check("busy_done", busy, 0);

    // collision: command wins, auto follows
    cmd_en = 1'b1;
    cmd_data = 4'd2;
    auto_en = 1'b1;
    auto_data = 4'd9;
    tick();
    check("col_cmd_ack", cmd_ack, 1);
    check("col_auto_ack0", auto_ack, 0);
    cmd_en = 1'b0;
    tick();
    check("col_auto_ack", auto_ack, 1);
    check("col_cmd_ack0", cmd_ack, 0);
    auto_en = 1'b0;
    tick();
    check("col_auto_once", auto_ack, 0);
    fs();
    check("col_out", brightness_out, 4'd9);
    tick();

    // equal request and idle frame_start
    req_cmd(4'd9);
    check("eq_busy", busy, 0);
    fs();
    check("eq_upd", brightness_upd, 0);
    check("eq_out", brightness_out, 4'd9);
    tick();

    // overwrite unapplied target
    req_cmd(4'd5);
    tick();
    req_cmd(4'd7);
    tick();
    fs();
    check("ovw_out", brightness_out, 4'd7);
    tick();

    // request together with frame_start
    req_cmd(4'd1);
    tick();
    tick();
    cmd_en = 1'b1;
    cmd_data = 4'd4;
    frame_start = 1'b1;
    tick();
    check("same_old", brightness_out, 4'd1);
    check("same_ack", cmd_ack, 1);
    cmd_en = 1'b0;
    frame_start = 1'b0;
    tick();
    tick();
    tick();
    check("same_wait", brightness_out, 4'd1);
    fs();
    check("same_new", brightness_out, 4'd4);
    tick();
    check("upd_total", upd_cnt, 5);

    // reset while waiting for a frame
    req_cmd(4'd0);
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check("rstw_out", brightness_out, 4'hF);
    check("rstw_busy", busy, 0);
    tick();
    reset_n = 1'b1;
    tick();
    check("rstw_after", brightness_out, 4'hF);
`else
    // get to 3, then ramp 3 -> 6
    req_cmd(4'd3);
    ramp_to(4'd3);
    upd_cnt = 0;
    req_cmd(4'd6);
    tick();
    for (int i = 0; i < 6; i++) begin
      fs();
      check("fade_step", brightness_out, exp_f[i]);
      tick();
      tick();
    end
    check("fade_busy", busy, 0);
    check("fade_upds", upd_cnt, 3);

    // retarget mid-fade
    req_cmd(4'd3);
    ramp_to(4'd3);
    req_cmd(4'd6);
    tick();
    fs();
    check("rt_first", brightness_out, 4'd4);
    tick();
    req_cmd(4'd2);
    fs();
    tick();
    tick();
    fs();
    check("rt_down1", brightness_out, 4'd3);
    tick();
    tick();
    fs();
    tick();
    tick();
    fs();
    check("rt_down2", brightness_out, 4'd2);

    // reset during HOLD
    tick();
    tick();
    fs();
    tick();
    req_cmd(4'd6);
    tick();
    fs();
    check("rh_step", brightness_out, 4'd3);
    tick();
    reset_n = 1'b0;
    #1;
    check("rh_out", brightness_out, 4'hF);
    check("rh_busy", busy, 0);
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    check("rh_idle", busy, 0);
    check("rh_after", brightness_out, 4'hF);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
